// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection and IF/ID pipeline register.
// Define FETCH_EARLY_BRANCH_EN to let BranchTakenE/ALUResultE redirect the PC from execute.
module fetch_stage #(
   parameter int N = 24
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] ResultW,
   input  logic [N-1:0] ALUResultE,
   input  logic         PCSrcW,
   input  logic         BranchTakenE,
   input  logic         StallF,
   input  logic         StallD,
   input  logic         FlushD,
   input  logic [N-1:0] instruction,
   output logic [N-1:0] PCF,
   output logic [N-1:0] InstrD,
   output logic         InstrD_vector,
   output logic [N-1:0] PCPlus8D
);

   logic [N-1:0] pc_q, pc_d;
   logic [N-1:0] instr_q, instr_d;
   logic         vector_q, vector_d;
   logic [N-1:0] pc_plus8_q, pc_plus8_d;
   logic [N-1:0] pc_plus4_f;
   logic [N-1:0] pc_next1;
   logic [N-1:0] pc_next;

   assign pc_plus4_f = pc_q + N'(4);
   assign pc_next1   = PCSrcW ? ResultW : pc_plus4_f;

`ifdef FETCH_EARLY_BRANCH_EN
   // Execute-stage branch resolution overrides a simultaneous writeback redirect.
   assign pc_next = BranchTakenE ? ALUResultE : pc_next1;
`else
   logic unused_branch_inputs;
   assign unused_branch_inputs = ^{BranchTakenE, ALUResultE};
   assign pc_next = pc_next1;
`endif

   // StallF and StallD are write enables: 1 lets the register update.
   always_comb begin
      pc_d = pc_q;
      if (StallF) begin
         pc_d = pc_next;
      end
   end

   always_comb begin
      instr_d    = instr_q;
      vector_d   = vector_q;
      pc_plus8_d = pc_plus8_q;
      if (FlushD) begin
         instr_d    = '0;
         vector_d   = 1'b0;
         pc_plus8_d = '0;
      end else if (StallD) begin
         instr_d    = instruction;
         vector_d   = instruction[20];
         pc_plus8_d = pc_plus4_f;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q       <= '0;
         instr_q    <= '0;
         vector_q   <= 1'b0;
         pc_plus8_q <= '0;
      end else begin
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         vector_q   <= vector_d;
         pc_plus8_q <= pc_plus8_d;
      end
   end

   assign PCF           = pc_q;
   assign InstrD        = instr_q;
   assign InstrD_vector = vector_q;
   assign PCPlus8D      = pc_plus8_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by randomized
// traffic, all checked against a cycle-level behavioural model of the fetch stage.
module tb_fetch_stage;

   localparam int N = 24;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [N-1:0] ResultW = '0;
   logic [N-1:0] ALUResultE = '0;
   logic         PCSrcW = 1'b0;
   logic         BranchTakenE = 1'b0;
   logic         StallF = 1'b0;
   logic         StallD = 1'b0;
   logic         FlushD = 1'b0;
   logic [N-1:0] instruction;
   logic [N-1:0] PCF;
   logic [N-1:0] InstrD;
   logic         InstrD_vector;
   logic [N-1:0] PCPlus8D;

   // Small combinational ROM, word-addressed by PCF (aliased to 256 words).
   logic [N-1:0] rom [256];
   assign instruction = rom[PCF[9:2]];

   fetch_stage #(.N(N)) dut (
      .clk(clk),
      .rst(rst),
      .ResultW(ResultW),
      .ALUResultE(ALUResultE),
      .PCSrcW(PCSrcW),
      .BranchTakenE(BranchTakenE),
      .StallF(StallF),
      .StallD(StallD),
      .FlushD(FlushD),
      .instruction(instruction),
      .PCF(PCF),
      .InstrD(InstrD),
      .InstrD_vector(InstrD_vector),
      .PCPlus8D(PCPlus8D)
   );

   always #5 clk = ~clk;

   int checkCount = 0;
   int failCount  = 0;

   // Reference model state: what each output should hold after the last edge.
   logic [N-1:0] mPc    = '0;
   logic [N-1:0] mInstr = '0;
   logic         mVec   = 1'b0;
   logic [N-1:0] mPc8   = '0;

   task automatic checkOutput(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
      checkCount++;
      if (got !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%06h expected 0x%06h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic checkAll(input string tag);
      checkOutput({tag, ".PCF"}, PCF, mPc);
      checkOutput({tag, ".InstrD"}, InstrD, mInstr);
      checkOutput({tag, ".InstrD_vector"}, {{(N-1){1'b0}}, InstrD_vector}, {{(N-1){1'b0}}, mVec});
      checkOutput({tag, ".PCPlus8D"}, PCPlus8D, mPc8);
   endtask

   // Drives one cycle of inputs, advances the model by one clock, then samples after the edge.
   task automatic applyStimulus(input logic sF, input logic sD, input logic fl,
                                input logic src, input logic [N-1:0] res,
                                input logic br, input logic [N-1:0] alu);
      logic [N-1:0] fetched;
      logic [N-1:0] target;
      StallF       = sF;
      StallD       = sD;
      FlushD       = fl;
      PCSrcW       = src;
      ResultW      = res;
      BranchTakenE = br;
      ALUResultE   = alu;
      fetched = rom[mPc[9:2]];
      target  = (mPc + 24'd4) % (1 << N);
      if (src) target = res;
`ifdef FETCH_EARLY_BRANCH_EN
      if (br) target = alu;
`endif
      if (fl) begin
         mInstr = '0;
         mVec   = 1'b0;
         mPc8   = '0;
      end else if (sD) begin
         mInstr = fetched;
         mVec   = fetched[20];
         mPc8   = mPc + 24'd4;
      end
      if (sF) mPc = target;
      @(posedge clk);
      #1;
   endtask

   task automatic stepPlain();
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = N'($urandom);

      #200;
      rst = 1'b1;
      #1;
      checkAll("reset_assert");
      #49;
      checkAll("reset_hold");
      #50;
      rst    = 1'b0;
      StallF = 1'b1;
      StallD = 1'b1;

      // Sequential fetch 4, 8, 12 after reset release.
      for (int i = 0; i < 3; i++) begin
         stepPlain();
         checkAll("seq");
      end

      // Writeback redirect to 0x40, then sequential.
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 24'h000040, 1'b0, '0);
      checkAll("pcsrc_redirect");
      checkOutput("pcsrc_target", PCF, 24'h000040);
      stepPlain();
      checkOutput("pcsrc_next", PCF, 24'h000044);

      // Simultaneous branch and writeback redirect.
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 24'h000040, 1'b1, 24'h000100);
      checkAll("branch_vs_pcsrc");
`ifdef FETCH_EARLY_BRANCH_EN
      checkOutput("branch_priority", PCF, 24'h000100);
`else
      checkOutput("branch_ignored", PCF, 24'h000040);
`endif

      // Two-cycle stall holds everything, then resume.
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
         checkAll("stall");
      end
      stepPlain();
      checkAll("stall_resume");

      // Flush with StallD set clears IF/ID while PC advances.
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
      checkAll("flush");
      checkOutput("flush_instr_zero", InstrD, '0);

      // Vector flag from instruction bit 20.
      rom[mPc[9:2]] = 24'h100000;
      stepPlain();
      checkAll("vector_set");
      checkOutput("vector_one", {{(N-1){1'b0}}, InstrD_vector}, 24'd1);
      rom[mPc[9:2]] = 24'h0FFFFF;
      stepPlain();
      checkAll("vector_clear");

      // Address wrap from 0xFFFFFC to 0.
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 24'hFFFFFC, 1'b0, '0);
      checkAll("wrap_setup");
      stepPlain();
      checkAll("wrap");
      checkOutput("wrap_pc_plus8", PCPlus8D, 24'h000000);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         logic         sF, sD, fl, src, br;
         logic [N-1:0] res, alu;
         sF  = ($urandom_range(0, 9) < 8);
         sD  = ($urandom_range(0, 9) < 8);
         fl  = ($urandom_range(0, 9) == 0);
         src = ($urandom_range(0, 6) == 0);
         br  = ($urandom_range(0, 6) == 0);
         res = N'($urandom) & 24'hFFFFFC;
         alu = N'($urandom) & 24'hFFFFFC;
         if ($urandom_range(0, 15) == 0) res = 24'hFFFFF8;
         applyStimulus(sF, sD, fl, src, res, br, alu);
         checkAll("random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
